// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory port, redirect input, consumer dequeue
// request and the head window presented to issue logic.
interface fetch_queue_if #(
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned INST_W  = 16
);
    localparam int unsigned DW = $clog2(ISSUE_W) + 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [ADDR_W*ISSUE_W-1:0] im_maddr;
    logic [INST_W*ISSUE_W-1:0] im_rdata;
    logic                      redirect;
    logic [ADDR_W-1:0]         redirect_pc;
    logic [DW-1:0]             deq_cnt;
    logic [INST_W*ISSUE_W-1:0] out_inst;
    logic [ADDR_W*ISSUE_W-1:0] out_pc;
    logic [ISSUE_W-1:0]        out_valid;
    logic [CW-1:0]             count;
    logic                      fetch_stall;

    // Fetch unit side.
    modport master (
        output im_maddr,
        input  im_rdata,
        input  redirect,
        input  redirect_pc,
        input  deq_cnt,
        output out_inst,
        output out_pc,
        output out_valid,
        output count,
        output fetch_stall
    );

    // Memory / issue-logic side.
    modport slave (
        input  im_maddr,
        output im_rdata,
        output redirect,
        output redirect_pc,
        output deq_cnt,
        input  out_inst,
        input  out_pc,
        input  out_valid,
        input  count,
        input  fetch_stall
    );
endinterface

// File: rtl/fetch_queue.sv
// N-wide instruction fetch unit: PC register, aligned group fetch from a
// combinational instruction memory, and a circular decoupling queue whose
// oldest ISSUE_W entries are presented to the issue logic each cycle.
module fetch_queue #(
    parameter int unsigned        ISSUE_W  = 2,
    parameter int unsigned        DEPTH    = 8,
    parameter int unsigned        ADDR_W   = 9,
    parameter int unsigned        INST_W   = 16,
    parameter bit [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = $clog2(ISSUE_W) + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic [INST_W-1:0] r_inst [DEPTH];
    logic [ADDR_W-1:0] r_ipc  [DEPTH];

    logic [ADDR_W-1:0] w_aligned;
    logic [CW-1:0]     w_off;
    logic [CW-1:0]     w_grp;
    logic [CW-1:0]     w_free;
    logic              w_room;
    logic              w_fetch;
    logic [CW-1:0]     w_deq;
    logic [CW-1:0]     w_eff;
    logic [CW-1:0]     w_count_nxt;
    logic [PW-1:0]     w_wr_idx [ISSUE_W];

    // Alignment, space check, dequeue clamp and next occupancy.
    always_comb begin
        w_aligned   = r_pc & ~ADDR_W'(ISSUE_W - 1);
        w_off       = CW'(r_pc & ADDR_W'(ISSUE_W - 1));
        w_grp       = CW'(ISSUE_W) - w_off;
        w_free      = CW'(DEPTH) - r_count;
        // Space is judged on registered occupancy only, so a full queue
        // reports a stall even while a redirect is also suppressing fetch.
        w_room      = (w_free >= CW'(ISSUE_W));
        w_fetch     = w_room && !bus.redirect;
        w_deq       = CW'(bus.deq_cnt);
        w_eff       = (w_deq > r_count) ? r_count : w_deq;
        w_count_nxt = r_count + (w_fetch ? w_grp : '0) - w_eff;
    end

    // Queue slot for each fetch lane; lanes below the offset are unused.
    always_comb begin
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            w_wr_idx[i] = r_tail + PW'(i) - PW'(w_off);
        end
    end

    // PC, pointers and occupancy; redirect flushes and overrides push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.redirect) begin
            r_pc    <= bus.redirect_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_fetch) begin
                r_pc   <= w_aligned + ADDR_W'(ISSUE_W);
                r_tail <= r_tail + PW'(w_grp);
            end
            r_head  <= r_head + PW'(w_eff);
            r_count <= w_count_nxt;
        end
    end

    // Queue storage write of the fetched lanes off..ISSUE_W-1 (not reset).
    always_ff @(posedge clk) begin
        if (w_fetch) begin
            for (int unsigned i = 0; i < ISSUE_W; i++) begin
                if (CW'(i) >= w_off) begin
                    r_inst[w_wr_idx[i]] <= bus.im_rdata[i*INST_W +: INST_W];
                    r_ipc[w_wr_idx[i]]  <= w_aligned + ADDR_W'(i);
                end
            end
        end
    end

    // Memory address lanes and the head window seen by issue logic.
    always_comb begin
        bus.im_maddr    = '0;
        bus.out_inst    = '0;
        bus.out_pc      = '0;
        bus.out_valid   = '0;
        bus.count       = r_count;
        bus.fetch_stall = !w_room;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            bus.im_maddr[i*ADDR_W +: ADDR_W] = w_aligned + ADDR_W'(i);
            bus.out_inst[i*INST_W +: INST_W] = r_inst[r_head + PW'(i)];
            bus.out_pc[i*ADDR_W +: ADDR_W]   = r_ipc[r_head + PW'(i)];
            bus.out_valid[i]                 = (r_count > CW'(i));
        end
    end

    logic w_unused;
    assign w_unused = ^{DW'(0)};
endmodule
